mod_addsub_serial: RTL and testbench

//  Word-serial modular adder/subtractor for the ECC core datapath. Computes
//  (a + b) mod p or (a - b) mod p. Subtraction uses the two's complement of b,

---
 rtl/mod_addsub_serial_if.sv | 24 ++
 rtl/mod_addsub_serial.sv | 151 +++++++++++++++
 tb/tb_mod_addsub_serial.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mod_addsub_serial_if.sv
// Request/response bundle for the word-serial modular adder/subtractor.
// The requester uses the master modport and the datapath uses the slave modport.
interface mod_addsub_serial_if #(
    parameter int unsigned WIDTH = 256
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b, p,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, p,
        output busy, done, result
    );
endinterface

// File: rtl/mod_addsub_serial.sv
// Word-serial (a + b) mod p / (a - b) mod p. One DIGIT-bit slice is handled per cycle:
// the raw sum or difference is formed first, then the trial correction by p.
module mod_addsub_serial #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DIGIT = 32
) (
    input logic                clk,
    input logic                rst,
    mod_addsub_serial_if.slave bus
);
    localparam int unsigned NW = WIDTH / DIGIT;
    localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(NW - 1);

    typedef enum logic [1:0] {StIdle, StAdd, StCorr, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
    logic [WIDTH-1:0] s_q, s_d, t_q, t_d, result_q, result_d;
    logic             op_q, op_d, carry_q, carry_d, cs_q, cs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] a_dig, b_dig, p_dig, s_dig, x_dig, y_dig;
    logic [DIGIT:0]   sum;
    logic             last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start) state_d = StAdd;
            StAdd:  if (last) state_d = StCorr;
            StCorr: if (last) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy   = (state_q == StAdd) || (state_q == StCorr);
        bus.done   = (state_q == StDone);
        bus.result = result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            s_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            cs_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            s_q      <= s_d;
            t_q      <= t_d;
            result_q <= result_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cs_q     <= cs_d;
            cnt_q    <= cnt_d;
        end
    end

    // ADD uses a + (b or ~b); CORR uses s + (~p or p). The +1 of each complement
    // rides in as the initial carry.
    always_comb begin
        a_dig = a_q[int'(cnt_q) * DIGIT +: DIGIT];
        b_dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];
        p_dig = p_q[int'(cnt_q) * DIGIT +: DIGIT];
        s_dig = s_q[int'(cnt_q) * DIGIT +: DIGIT];
        last  = (cnt_q == LastCnt);
        if (state_q == StCorr) begin
            x_dig = s_dig;
            y_dig = op_q ? p_dig : ~p_dig;
        end else begin
            x_dig = a_dig;
            y_dig = op_q ? ~b_dig : b_dig;
        end
        sum = {1'b0, x_dig} + {1'b0, y_dig} + {{DIGIT{1'b0}}, carry_q};
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        s_d      = s_q;
        t_d      = t_q;
        result_d = result_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cs_d     = cs_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    p_d     = bus.p;
                    op_d    = bus.op;
                    carry_d = bus.op;
                    cnt_d   = '0;
                end
            end
            StAdd: begin
                s_d[int'(cnt_q) * DIGIT +: DIGIT] = sum[DIGIT-1:0];
                if (last) begin
                    cs_d    = sum[DIGIT];
                    carry_d = ~op_q;
                    cnt_d   = '0;
                end else begin
                    carry_d = sum[DIGIT];
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StCorr: begin
                t_d[int'(cnt_q) * DIGIT +: DIGIT] = sum[DIGIT-1:0];
                carry_d = sum[DIGIT];
                if (last) begin
                    // sum[DIGIT] here is the final correction carry ct.
                    if (op_q) begin
                        result_d = cs_q ? s_q : t_d;
                    end else begin
                        result_d = (cs_q || sum[DIGIT]) ? t_d : s_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: ;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mod_addsub_serial.sv
// Self-checking bench for mod_addsub_serial: directed corner cases plus random operands
// compared against a plain-arithmetic modular reference.
module tb_mod_addsub_serial;
    localparam int unsigned WIDTH = 256;
    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mod_addsub_serial_if #(.WIDTH(WIDTH)) bus ();

    mod_addsub_serial #(.WIDTH(WIDTH), .DIGIT(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [255:0] ref_model(input logic [255:0] x, input logic [255:0] y,
                                               input logic [255:0] m, input logic o);
        logic [256:0] r;
        if (!o) begin
            r = {1'b0, x} + {1'b0, y};
            if (r >= {1'b0, m}) r = r - {1'b0, m};
        end else if (x >= y) begin
            r = {1'b0, x - y};
        end else begin
            r = {1'b0, x} + {1'b0, m} - {1'b0, y};
        end
        return r[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [255:0] ia, input logic [255:0] ib,
                          input logic iop, input bit disturb);
        int   cyc;
        logic busy_ok;
        logic [255:0] exp;
        exp = ref_model(ia, ib, P, iop);
        @(negedge clk);
        bus.a = ia; bus.b = ib; bus.p = P; bus.op = iop; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (disturb && cyc == 2) begin
                bus.a = rand256(); bus.b = rand256(); bus.p = rand256(); bus.op = ~iop;
            end
            bus.start = (disturb && cyc == 3);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, " latency"}, 256'(cyc), 256'd17);
        chk({tag, " busy_during"}, {255'd0, busy_ok}, 256'd1);
        chk({tag, " busy_at_done"}, {255'd0, bus.busy}, 256'd0);
        chk({tag, " result"}, bus.result, exp);
        if (disturb) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, " done_pulse"}, {255'd0, bus.done}, 256'd0);
        chk({tag, " idle_busy"}, {255'd0, bus.busy}, 256'd0);
        chk({tag, " result_hold"}, bus.result, exp);
    endtask

    initial begin
        int   cyc;
        logic seen_done;
        logic [255:0] ra, rb;
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.p = P;
        repeat (3) @(negedge clk);
        chk("reset busy", {255'd0, bus.busy}, 256'd0);
        chk("reset done", {255'd0, bus.done}, 256'd0);
        chk("reset result", bus.result, 256'd0);
        rst = 1'b0;

        run_op("add_small", 256'd5, 256'd7, 1'b0, 1'b0);
        run_op("add_zero", 256'd0, 256'd0, 1'b0, 1'b0);
        run_op("add_wrap", P - 256'd1, 256'd2, 1'b0, 1'b0);
        run_op("add_max", P - 256'd1, P - 256'd1, 1'b0, 1'b0);
        run_op("add_eq_p", P - 256'd100, 256'd100, 1'b0, 1'b0);
        run_op("sub_small", 256'd9, 256'd4, 1'b1, 1'b0);
        run_op("sub_equal", 256'd123, 256'd123, 1'b1, 1'b0);
        run_op("sub_borrow", 256'd3, 256'd5, 1'b1, 1'b0);
        run_op("sub_disturb", 256'd3, 256'd5, 1'b1, 1'b1);
        run_op("add_disturb", P - 256'd7, 256'd11, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            ra = rand256() % P;
            rb = rand256() % P;
            run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(1, 0)), 1'b0);
        end

        // Abort mid-operation with reset; the previous result is nonzero.
        @(negedge clk);
        bus.a = P - 256'd1; bus.b = 256'd2; bus.p = P; bus.op = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", {255'd0, bus.busy}, 256'd0);
        chk("abort done", {255'd0, bus.done}, 256'd0);
        chk("abort result", bus.result, 256'd0);
        seen_done = 1'b0;
        for (cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        chk("abort no_done", {255'd0, seen_done}, 256'd0);
        run_op("after_abort", 256'd9, 256'd4, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
